swi_conditioner: RTL and testbench
==================================

# swi_conditioner

Input-conditioning stage between the raw board switches and the top-level design's `SWI` input. It synchronises each asynchronous switch bit into `clk_2`, debounces it with a per-bit consecutive-sample counter, and emits a clean level, one-cycle rise/fall pulses and a per-bit toggle state. Downstream logic (LED/SEG mirroring, single-step control of the processor debug view) consumes `swi_clean` and the pulses in place of raw switches.

## Interface
- `NBITS`, 8: number of switch bits.
- `DB_CYCLES`, 4: consecutive synchronised samples required to accept a change; legal range 1..65535.

- `clk_2`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `swi_raw`  in  NBITS  raw switch levels, asynchronous to `clk_2`.
- `swi_clean`  out  NBITS  debounced level, registered.
- `swi_rise`  out  NBITS  one-cycle pulse per bit when `swi_clean` goes 0→1, registered.
- `swi_fall`  out  NBITS  one-cycle pulse per bit when `swi_clean` goes 1→0, registered.
- `swi_toggle`  out  NBITS  per-bit flip-flop inverted on every rise of that bit, registered.
- `any_change`  out  1  OR-reduction of `swi_rise | swi_fall`; combinational from registers only.

## Operation
- Per bit: 2-stage synchroniser `s1 <= swi_raw`, `s2 <= s1`; `s2` is the only sampled value downstream.
- Per bit counter `cnt`, width `max(1, $clog2(DB_CYCLES))`, unsigned, never wraps.
- Each edge, per bit, exactly one of:
  - `s2 == clean`: `cnt <= 0`; no pulse.
  - `s2 != clean` and `cnt == DB_CYCLES-1`: `clean <= s2`; `cnt <= 0`; `rise <= s2`, `fall <= ~s2`; if `s2`, `toggle <= ~toggle`.
  - otherwise: `cnt <= cnt + 1`.
- `rise`/`fall` are 0 on every edge not in the acceptance case; each pulse lasts exactly one cycle.
- Bits are fully independent; simultaneous changes on several bits each produce their own pulses in the same cycle.
- Glitch rejection: any sample with `s2 == clean` before acceptance discards progress (`cnt` back to 0).
- `DB_CYCLES == 1`: a change is accepted on the first edge `s2` differs.

## Timing
- Reset (asynchronous assert, synchronous-effect deassert): `s1`, `s2`, `cnt`, `swi_clean`, `swi_rise`, `swi_fall`, `swi_toggle` = 0; `any_change` = 0.
- Switches already high at reset release are seen as a change: rise pulses appear DB_CYCLES+1 edges after release (first edge counted as edge 0).
- Latency: `swi_raw` captured into `s1` at edge 0 and stable thereafter → `swi_clean` and pulse update at edge DB_CYCLES+1 (5 edges for default).
- Minimum accepted pulse width on `swi_raw`: DB_CYCLES cycles as seen at `s2`; shorter excursions produce no output activity.
- Back-to-back: a new opposite change may begin counting on the edge after acceptance; minimum spacing between two pulses of one bit is DB_CYCLES cycles.
- `reset_n` asserted mid-count or during a pulse: all state cleared immediately; pulse is dropped, no partial acceptance survives.
- `any_change` valid in the same cycle as the pulses it summarises.

## Test plan
- Reset with `swi_raw=0x00`, release, hold 20 cycles -> all outputs 0 throughout, no pulses.
- `swi_raw` 0x00→0x05 at edge 0, held -> `swi_clean=0x05`, `swi_rise=0x05`, `any_change=1` at edge 5 only; `swi_toggle=0x05`; edge 6 pulses 0.
- Bit 0 high for 3 cycles then low (DB_CYCLES=4) -> no change on any output; repeat with 4-cycle hold -> accepted at edge 5, then `swi_fall[0]` pulse 4 cycles after the low level reaches `s2`.
- Bit 3 toggled 0→1→0→1 with 10-cycle spacing -> three pulses (rise, fall, rise), `swi_toggle[3]` 0→1→1→0.
- `swi_raw=0xFF` held through reset release -> `swi_rise=0xFF` single pulse at edge 5 after release; `reset_n` pulsed low at cycle 3 of a second change -> outputs return to 0 asynchronously, change re-qualified from scratch.
- DB_CYCLES=1 build: 0x00→0x80 -> `swi_clean=0x80` and `swi_rise=0x80` at edge 2.

Source files
------------

// File: rtl/swi_conditioner_if.sv
// Switch-conditioning bus: raw switch levels in, debounced level/pulses/toggle out.
interface swi_conditioner_if #(
   parameter int unsigned NBITS = 8
);
   logic [NBITS-1:0] swi_raw;
   logic [NBITS-1:0] swi_clean;
   logic [NBITS-1:0] swi_rise;
   logic [NBITS-1:0] swi_fall;
   logic [NBITS-1:0] swi_toggle;
   logic             any_change;

   modport master (
      output swi_raw,
      input  swi_clean,
      input  swi_rise,
      input  swi_fall,
      input  swi_toggle,
      input  any_change
   );

   modport slave (
      input  swi_raw,
      output swi_clean,
      output swi_rise,
      output swi_fall,
      output swi_toggle,
      output any_change
   );
endinterface

// File: rtl/swi_conditioner.sv
// Per-bit switch synchroniser and consecutive-sample debouncer with edge pulses and
// toggle state.
module swi_conditioner #(
   parameter int unsigned NBITS     = 8,
   parameter int unsigned DB_CYCLES = 4
) (
   input logic              clk_2,
   input logic              reset_n,
   swi_conditioner_if.slave bus
);

   localparam int unsigned    CntW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

   logic [NBITS-1:0] s1_q, s2_q;
   logic [NBITS-1:0] clean_q, clean_d;
   logic [NBITS-1:0] rise_q, rise_d;
   logic [NBITS-1:0] fall_q, fall_d;
   logic [NBITS-1:0] toggle_q, toggle_d;
   logic [CntW-1:0]  cnt_q [NBITS];
   logic [CntW-1:0]  cnt_d [NBITS];

   // The counter tops out at CntMax and is cleared on acceptance, so it never wraps.
   always_comb begin
      clean_d  = clean_q;
      toggle_d = toggle_q;
      rise_d   = '0;
      fall_d   = '0;
      for (int b = 0; b < int'(NBITS); b++) begin
         cnt_d[b] = '0;
         if (s2_q[b] != clean_q[b]) begin
            if (cnt_q[b] == CntMax) begin
               clean_d[b] = s2_q[b];
               rise_d[b]  = s2_q[b];
               fall_d[b]  = ~s2_q[b];
               if (s2_q[b]) begin
                  toggle_d[b] = ~toggle_q[b];
               end
            end else begin
               cnt_d[b] = cnt_q[b] + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         clean_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         toggle_q <= '0;
         for (int b = 0; b < int'(NBITS); b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         s1_q     <= bus.swi_raw;
         s2_q     <= s1_q;
         clean_q  <= clean_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
         for (int b = 0; b < int'(NBITS); b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   assign bus.swi_clean  = clean_q;
   assign bus.swi_rise   = rise_q;
   assign bus.swi_fall   = fall_q;
   assign bus.swi_toggle = toggle_q;
   assign bus.any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_swi_conditioner.sv
// Bench for swi_conditioner: DB_CYCLES=4 and DB_CYCLES=1 builds share raw input and reset,
// both checked every edge against a sample-window reference model.
module tb_swi_conditioner;

   localparam int NBITS = 8;

   logic             clk_2   = 1'b0;
   logic             reset_n = 1'b0;
   logic [NBITS-1:0] raw     = '0;

   always #5 clk_2 = ~clk_2;

   swi_conditioner_if #(.NBITS(NBITS)) bus4 ();
   swi_conditioner_if #(.NBITS(NBITS)) bus1 ();

   assign bus4.swi_raw = raw;
   assign bus1.swi_raw = raw;

   swi_conditioner #(.NBITS(NBITS), .DB_CYCLES(4)) u_dut4 (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus4)
   );

   swi_conditioner #(.NBITS(NBITS), .DB_CYCLES(1)) u_dut1 (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: a change is accepted at an edge when the last DB samples, none of
   // them earlier than the previous acceptance of that bit, all differ from the clean level.
   int               dbv [2] = '{4, 1};
   logic [NBITS-1:0] raw_q [$];
   logic [NBITS-1:0] samp_q [$];
   int               edge_n;
   logic [NBITS-1:0] m_clean [2];
   logic [NBITS-1:0] m_rise [2];
   logic [NBITS-1:0] m_fall [2];
   logic [NBITS-1:0] m_tog [2];
   int               last_acc [2][NBITS];

   task automatic model_reset();
      raw_q.delete();
      samp_q.delete();
      edge_n = 0;
      for (int i = 0; i < 2; i++) begin
         m_clean[i] = '0;
         m_rise[i]  = '0;
         m_fall[i]  = '0;
         m_tog[i]   = '0;
         for (int b = 0; b < NBITS; b++) last_acc[i][b] = -1;
      end
   endtask

   task automatic model_edge();
      logic [NBITS-1:0] sample;
      bit               ok;
      // Two-flop delay: edge n sees the raw level present at edge n-2, zero before that.
      sample = (edge_n >= 2) ? raw_q[edge_n-2] : '0;
      raw_q.push_back(raw);
      samp_q.push_back(sample);
      for (int i = 0; i < 2; i++) begin
         m_rise[i] = '0;
         m_fall[i] = '0;
         for (int b = 0; b < NBITS; b++) begin
            if (edge_n - last_acc[i][b] >= dbv[i]) begin
               ok = 1'b1;
               for (int k = edge_n - dbv[i] + 1; k <= edge_n; k++) begin
                  if (samp_q[k][b] == m_clean[i][b]) ok = 1'b0;
               end
               if (ok) begin
                  m_clean[i][b] = ~m_clean[i][b];
                  if (m_clean[i][b]) begin
                     m_rise[i][b] = 1'b1;
                     m_tog[i][b]  = ~m_tog[i][b];
                  end else begin
                     m_fall[i][b] = 1'b1;
                  end
                  last_acc[i][b] = edge_n;
               end
            end
         end
      end
      edge_n++;
   endtask

   task automatic compare_all();
      check("db4_clean",  32'(bus4.swi_clean),  32'(m_clean[0]));
      check("db4_rise",   32'(bus4.swi_rise),   32'(m_rise[0]));
      check("db4_fall",   32'(bus4.swi_fall),   32'(m_fall[0]));
      check("db4_toggle", 32'(bus4.swi_toggle), 32'(m_tog[0]));
      check("db4_any",    32'(bus4.any_change), 32'(|(m_rise[0] | m_fall[0])));
      check("db1_clean",  32'(bus1.swi_clean),  32'(m_clean[1]));
      check("db1_rise",   32'(bus1.swi_rise),   32'(m_rise[1]));
      check("db1_fall",   32'(bus1.swi_fall),   32'(m_fall[1]));
      check("db1_toggle", 32'(bus1.swi_toggle), 32'(m_tog[1]));
      check("db1_any",    32'(bus1.any_change), 32'(|(m_rise[1] | m_fall[1])));
   endtask

   // Entered and left at a falling edge.
   task automatic tick(input logic [NBITS-1:0] v);
      raw = v;
      @(posedge clk_2);
      #1;
      if (reset_n) model_edge();
      compare_all();
      @(negedge clk_2);
   endtask

   task automatic do_reset(input logic [NBITS-1:0] v);
      raw     = v;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_clean", 32'({bus4.swi_clean, bus1.swi_clean}), 32'h0);
      check("rst_pulse", 32'({bus4.swi_rise | bus4.swi_fall, bus1.swi_rise | bus1.swi_fall}),
            32'h0);
      check("rst_toggle", 32'({bus4.swi_toggle, bus1.swi_toggle}), 32'h0);
      check("rst_any", 32'({bus4.any_change, bus1.any_change}), 32'h0);
      repeat (2) @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   logic [NBITS-1:0] cur;

   initial begin
      model_reset();
      @(negedge clk_2);

      // Idle after reset.
      do_reset('0);
      repeat (20) tick('0);

      // 0x00 -> 0x05: acceptance on edge 5 for DB=4.
      do_reset('0);
      for (int e = 0; e < 8; e++) begin
         tick(8'h05);
         if (e == 4) check("db4_e4_rise", 32'(bus4.swi_rise), 32'h00);
         if (e == 5) begin
            check("db4_e5_clean", 32'(bus4.swi_clean), 32'h05);
            check("db4_e5_rise", 32'(bus4.swi_rise), 32'h05);
            check("db4_e5_any", 32'(bus4.any_change), 32'h1);
         end
         if (e == 6) check("db4_e6_rise", 32'(bus4.swi_rise), 32'h00);
      end
      check("db4_tog05", 32'(bus4.swi_toggle), 32'h05);

      // Glitch rejection then a qualifying 4-cycle pulse on bit 0.
      do_reset('0);
      repeat (3) tick(8'h01);
      repeat (10) tick(8'h00);
      check("db4_glitch", 32'(bus4.swi_clean), 32'h00);
      repeat (4) tick(8'h01);
      repeat (12) tick(8'h00);

      // Bit 3: rise, fall, rise at 10-cycle spacing.
      do_reset('0);
      repeat (10) tick(8'h08);
      repeat (10) tick(8'h00);
      repeat (10) tick(8'h08);
      check("db4_b3_clean", 32'(bus4.swi_clean[3]), 32'h1);
      check("db4_b3_tog", 32'(bus4.swi_toggle[3]), 32'h0);

      // 0xFF held through reset, then a second change cut by reset at its 3rd cycle.
      do_reset(8'hFF);
      for (int e = 0; e < 7; e++) begin
         tick(8'hFF);
         if (e == 5) check("db4_ff_rise", 32'(bus4.swi_rise), 32'hFF);
      end
      repeat (3) tick(8'h00);
      do_reset(8'h00);
      repeat (8) tick(8'h00);

      // DB=1 build accepts at edge 2.
      do_reset('0);
      for (int e = 0; e < 4; e++) begin
         tick(8'h80);
         if (e == 1) check("db1_e1_rise", 32'(bus1.swi_rise), 32'h00);
         if (e == 2) begin
            check("db1_e2_clean", 32'(bus1.swi_clean), 32'h80);
            check("db1_e2_rise", 32'(bus1.swi_rise), 32'h80);
         end
      end

      // Random bursts, glitches, multi-bit changes and occasional resets.
      do_reset('0);
      cur = '0;
      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(0, 9))
            0:       cur = NBITS'($urandom);
            1, 2:    cur = cur ^ (NBITS'(1) << $urandom_range(0, NBITS - 1));
            default: ;
         endcase
         if ($urandom_range(0, 199) == 0) do_reset(cur);
         tick(cur);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
